// File: rtl/sm_als_spi.sv
// rtl/sm_als_spi.sv - SPI master for the ambient light sensor (16-bit frame, 8-bit result)
// Runs one conversion per start request or per auto period and strobes each sample with dataValid.
module sm_als_spi #(
  parameter int SCK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic [7:0] data,
  output logic       err,
  output logic       dataValid,
  output logic       alsCS,
  output logic       alsSCK,
  input  logic       alsSDO
);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  localparam logic [7:0] HALF_LAST = 8'(SCK_DIV - 1);
  localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [PW-1:0] PERIOD_LAST = PW'((SAMPLE_PERIOD > 0) ? SAMPLE_PERIOD - 1 : 0);

  state_t          state, state_nx;
  logic [7:0]      hcnt, hcnt_nx;
  logic [3:0]      bcnt, bcnt_nx;
  logic [15:0]     shift_q;
  logic [PW-1:0]   pcnt;
  logic            sdo_meta, sdo_s;
  logic            pending, pending_nx;
  logic            cs_nx, sck_nx, busy_nx;
  logic            half_done, launch, sample, result, wrap;

  assign half_done = (hcnt == HALF_LAST);
  assign wrap      = (SAMPLE_PERIOD != 0) && (pcnt == PERIOD_LAST);

  always_comb begin
    state_nx = state;
    hcnt_nx  = hcnt + 8'd1;
    bcnt_nx  = bcnt;
    cs_nx    = alsCS;
    sck_nx   = alsSCK;
    busy_nx  = busy;
    launch   = 1'b0;
    sample   = 1'b0;
    result   = 1'b0;
    case (state)
      IDLE: begin
        hcnt_nx = 8'd0;
        if (start || pending) begin
          launch   = 1'b1;
          state_nx = SETUP;
          cs_nx    = 1'b0;
          busy_nx  = 1'b1;
        end
      end
      SETUP: begin
        if (half_done) begin
          state_nx = SHIFT;
          sck_nx   = 1'b0;
          hcnt_nx  = 8'd0;
          bcnt_nx  = 4'd0;
        end
      end
      SHIFT: begin
        if (half_done) begin
          hcnt_nx = 8'd0;
          if (!alsSCK) begin
            sck_nx = 1'b1;
            sample = 1'b1;
          end else if (bcnt == 4'd15) begin
            state_nx = HOLD;
            cs_nx    = 1'b1;
          end else begin
            sck_nx  = 1'b0;
            bcnt_nx = bcnt + 4'd1;
          end
        end
      end
      HOLD: begin
        if (half_done) begin
          state_nx = IDLE;
          hcnt_nx  = 8'd0;
          busy_nx  = 1'b0;
          result   = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // A launch consumes any coincident wrap, so a start on a wrap edge never doubles up.
  always_comb begin
    pending_nx = pending;
    if (launch)    pending_nx = 1'b0;
    else if (wrap) pending_nx = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hcnt      <= 8'd0;
      bcnt      <= 4'd0;
      alsCS     <= 1'b1;
      alsSCK    <= 1'b1;
      busy      <= 1'b0;
      dataValid <= 1'b0;
      data      <= 8'd0;
      err       <= 1'b0;
      shift_q   <= 16'd0;
      pending   <= 1'b0;
      pcnt      <= '0;
      sdo_meta  <= 1'b0;
      sdo_s     <= 1'b0;
    end else begin
      state     <= state_nx;
      hcnt      <= hcnt_nx;
      bcnt      <= bcnt_nx;
      alsCS     <= cs_nx;
      alsSCK    <= sck_nx;
      busy      <= busy_nx;
      dataValid <= result;
      pending   <= pending_nx;
      sdo_meta  <= alsSDO;
      sdo_s     <= sdo_meta;
      if (sample) shift_q <= {shift_q[14:0], sdo_s};
      if (result) begin
        data <= shift_q[11:4];
        err  <= (|shift_q[15:12]) | (|shift_q[3:0]);
      end
      if (wrap || SAMPLE_PERIOD == 0) pcnt <= '0;
      else                            pcnt <= pcnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_sm_als_spi.sv
// tb/tb_sm_als_spi.sv - directed self-checking bench for sm_als_spi
// Edge indices: a value sampled on the negedge after posedge n is the register state set at edge n.
module tb_sm_als_spi;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0, rst_auto_n = 1'b0;
  logic       start = 1'b0, start_auto = 1'b0;
  logic       busy, err, data_valid, als_cs, als_sck;
  logic [7:0] data;
  logic       sdo = 1'b0;
  logic       busy_a, err_a, dv_a, cs_a, sck_a;
  logic [7:0] data_a;
  logic       sdo_a = 1'b0;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  logic [15:0] frame = 16'h0000;
  logic [15:0] frame_a = 16'h0A50;
  int idx = 15;
  int idx_a = 15;

  sm_als_spi #(.SCK_DIV(4), .SAMPLE_PERIOD(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .data(data), .err(err),
    .dataValid(data_valid), .alsCS(als_cs), .alsSCK(als_sck), .alsSDO(sdo)
  );

  sm_als_spi #(.SCK_DIV(4), .SAMPLE_PERIOD(200)) u_auto (
    .clk(clk), .rst_n(rst_auto_n), .start(start_auto), .busy(busy_a), .data(data_a), .err(err_a),
    .dataValid(dv_a), .alsCS(cs_a), .alsSCK(sck_a), .alsSDO(sdo_a)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Sensor models: present the next frame bit on each SCK falling edge while selected.
  always @(negedge als_cs) idx = 15;
  always @(negedge als_sck) begin
    if (!als_cs) begin
      if (idx >= 0) sdo = frame[idx];
      idx = idx - 1;
    end
  end
  always @(negedge cs_a) idx_a = 15;
  always @(negedge sck_a) begin
    if (!cs_a) begin
      if (idx_a >= 0) sdo_a = frame_a[idx_a];
      idx_a = idx_a - 1;
    end
  end

  task automatic test_reset();
    int odd;
    odd = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (als_cs !== 1'b1)     begin bad++; $display("FAIL reset_cs got=%b exp=1", als_cs); end
    total++; if (als_sck !== 1'b1)    begin bad++; $display("FAIL reset_sck got=%b exp=1", als_sck); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (data !== 8'h00)      begin bad++; $display("FAIL reset_data got=%h exp=00", data); end
    total++; if (err !== 1'b0)        begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_dv got=%b exp=0", data_valid); end
    rst_n = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (als_cs !== 1'b1 || data_valid !== 1'b0) odd++;
    end
    total++; if (odd != 0) begin bad++; $display("FAIL idle_quiet got=%0d active samples exp=0", odd); end
  endtask

  task automatic run_conv(input logic [15:0] frame_v, input logic [7:0] exp_d, input logic exp_e, input string name);
    int e, c, first_rise, rises, dv_cnt, dv_at, busy_cnt;
    logic prev_sck, busy_at_dv;
    logic [7:0] d_at;
    logic e_at;
    first_rise = -1; rises = 0; dv_cnt = 0; dv_at = -1; busy_cnt = 0;
    prev_sck = 1'b1; busy_at_dv = 1'bx; d_at = 8'hxx; e_at = 1'bx;
    frame = frame_v;
    @(negedge clk);
    start = 1'b1;
    e = cyc + 1;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      c = cyc;
      if (i == 0) start = 1'b0;
      if (als_sck && !prev_sck && !als_cs) begin
        rises++;
        if (first_rise < 0) first_rise = c;
      end
      prev_sck = als_sck;
      if (busy) busy_cnt++;
      if (data_valid) begin
        dv_cnt++; dv_at = c; busy_at_dv = busy; d_at = data; e_at = err;
      end
    end
    total++; if (first_rise != e + 8) begin bad++; $display("FAIL %s first_rise got=E+%0d exp=E+8", name, first_rise - e); end
    total++; if (rises != 16)         begin bad++; $display("FAIL %s sck_rises got=%0d exp=16", name, rises); end
    total++; if (dv_cnt != 1)         begin bad++; $display("FAIL %s dv_count got=%0d exp=1", name, dv_cnt); end
    total++; if (dv_at != e + 136)    begin bad++; $display("FAIL %s dv_edge got=E+%0d exp=E+136", name, dv_at - e); end
    total++; if (busy_cnt != 136)     begin bad++; $display("FAIL %s busy_cycles got=%0d exp=136", name, busy_cnt); end
    total++; if (busy_at_dv !== 1'b0) begin bad++; $display("FAIL %s busy_at_dv got=%b exp=0", name, busy_at_dv); end
    total++; if (d_at !== exp_d)      begin bad++; $display("FAIL %s data got=%h exp=%h", name, d_at, exp_d); end
    total++; if (e_at !== exp_e)      begin bad++; $display("FAIL %s err got=%b exp=%b", name, e_at, exp_e); end
  endtask

  task automatic test_single();
    run_conv(16'h0A50, 8'hA5, 1'b0, "single");
  endtask

  task automatic test_frame_error();
    run_conv(16'h8A50, 8'hA5, 1'b1, "frame_err");
    run_conv(16'h0FF0, 8'hFF, 1'b0, "frame_ok");
  endtask

  task automatic test_back_to_back();
    int e, c, falls, l0, l1, gap, dv_cnt;
    int rises[2];
    logic prev_cs, prev_sck;
    falls = 0; l0 = -1; l1 = -1; gap = 0; dv_cnt = 0; rises[0] = 0; rises[1] = 0;
    prev_cs = 1'b1; prev_sck = 1'b1;
    frame = 16'h0A50;
    @(negedge clk);
    start = 1'b1;
    e = cyc + 1;
    for (int i = 0; i < 450; i++) begin
      @(negedge clk);
      c = cyc;
      if (c == e + 259) start = 1'b0;
      if (!als_cs && prev_cs) begin
        if (falls == 0) l0 = c;
        if (falls == 1) l1 = c;
        falls++;
      end
      if (als_sck && !prev_sck && !als_cs && falls >= 1 && falls <= 2) rises[falls-1]++;
      if (als_cs && c > e && c < e + 137) gap++;
      if (data_valid) dv_cnt++;
      prev_cs = als_cs;
      prev_sck = als_sck;
    end
    total++; if (falls != 2)     begin bad++; $display("FAIL b2b_frames got=%0d exp=2", falls); end
    total++; if (l0 != e)        begin bad++; $display("FAIL b2b_first got=E+%0d exp=E+0", l0 - e); end
    total++; if (l1 != e + 137)  begin bad++; $display("FAIL b2b_second got=E+%0d exp=E+137", l1 - e); end
    total++; if (rises[0] != 16) begin bad++; $display("FAIL b2b_rises0 got=%0d exp=16", rises[0]); end
    total++; if (rises[1] != 16) begin bad++; $display("FAIL b2b_rises1 got=%0d exp=16", rises[1]); end
    total++; if (gap < 4)        begin bad++; $display("FAIL b2b_cs_gap got=%0d exp>=4", gap); end
    total++; if (dv_cnt != 2)    begin bad++; $display("FAIL b2b_dv_count got=%0d exp=2", dv_cnt); end
  endtask

  task automatic test_reset_mid();
    int e, odd;
    odd = 0;
    frame = 16'h0A50;
    @(negedge clk);
    start = 1'b1;
    e = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < e + 62) @(negedge clk);
    total++; if (als_cs !== 1'b0) begin bad++; $display("FAIL mid_in_frame cs got=%b exp=0", als_cs); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (als_cs !== 1'b1)     begin bad++; $display("FAIL mid_cs got=%b exp=1", als_cs); end
    total++; if (als_sck !== 1'b1)    begin bad++; $display("FAIL mid_sck got=%b exp=1", als_sck); end
    total++; if (data !== 8'h00)      begin bad++; $display("FAIL mid_data got=%h exp=00", data); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL mid_busy got=%b exp=0", busy); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (data_valid !== 1'b0 || als_cs !== 1'b1) odd++;
    end
    total++; if (odd != 0) begin bad++; $display("FAIL mid_quiet got=%0d active samples exp=0", odd); end
    run_conv(16'h0A50, 8'hA5, 1'b0, "after_reset");
  endtask

  task automatic test_auto();
    int r0, c;
    int got[$];
    int expd[5];
    @(negedge clk);
    rst_auto_n = 1'b1;
    r0 = cyc + 1;
    expd[0] = r0 + 336; expd[1] = r0 + 536; expd[2] = r0 + 735; expd[3] = r0 + 936; expd[4] = r0 + 1136;
    c = cyc;
    while (c < r0 + 1200) begin
      @(negedge clk);
      c = cyc;
      if (c == r0 + 598) start_auto = 1'b1;
      if (c == r0 + 599) start_auto = 1'b0;
      if (dv_a) got.push_back(c);
    end
    total++; if (got.size() != 5) begin bad++; $display("FAIL auto_count got=%0d exp=5", got.size()); end
    for (int i = 0; i < 5; i++) begin
      if (i < got.size()) begin
        total++;
        if (got[i] != expd[i]) begin bad++; $display("FAIL auto_dv%0d got=R+%0d exp=R+%0d", i, got[i] - r0, expd[i] - r0); end
      end
    end
    total++; if (data_a !== 8'hA5) begin bad++; $display("FAIL auto_data got=%h exp=a5", data_a); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_frame_error();
    test_back_to_back();
    test_reset_mid();
    test_auto();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
